// File: rtl/textram_ctrl_if.sv
// CPU word-access bus into the text RAM controller: request held until a one-cycle ack.
interface textram_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  cpu_req;
    logic                  cpu_wr;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wrdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rddata;

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wrdata,
        input  cpu_ack, cpu_rddata
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wrdata,
        output cpu_ack, cpu_rddata
    );
endinterface

// File: rtl/textram_ctrl.sv
// CPU-side port sequencer for the dual-port text RAM: CPU word accesses take priority,
// a fill engine (screen clear / attribute fill) uses every idle RAM cycle.
module textram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    textram_ctrl_if.slave         cpu,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH:0]   fill_count,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  fill_abort,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wrdata,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_rddata
);
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state, state_n;
    logic [ADDR_WIDTH-1:0] fill_addr, fill_addr_n;
    logic [CNT_WIDTH-1:0]  fill_remaining, fill_remaining_n;
    logic [DATA_WIDTH-1:0] fill_word, fill_word_n;
    logic                  fill_busy_n, fill_done_n;
    logic                  cpu_ack_q;
    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] rd_hold;
    logic                  cpu_issue;
    logic                  fill_wr;

    // Next-state, fill bookkeeping and the RAM port mux (CPU issue wins).
    always_comb begin
        state_n          = state;
        fill_addr_n      = fill_addr;
        fill_remaining_n = fill_remaining;
        fill_word_n      = fill_word;
        fill_busy_n      = fill_busy;
        fill_done_n      = 1'b0;
        fill_wr          = 1'b0;
        cpu_issue        = cpu.cpu_req && !cpu_ack_q && !rd_pend;

        case (state)
            S_IDLE: begin
                if (fill_start) begin
                    fill_addr_n      = fill_base;
                    fill_word_n      = fill_data;
                    fill_remaining_n = (fill_count > MAX_COUNT) ? MAX_COUNT : fill_count;
                    fill_busy_n      = 1'b1;
                    if (fill_count == '0) begin
                        state_n     = S_DONE;
                        fill_done_n = 1'b1;
                    end else begin
                        state_n = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (fill_abort) begin
                    state_n     = S_IDLE;
                    fill_busy_n = 1'b0;
                end else if (!cpu_issue) begin
                    fill_wr          = 1'b1;
                    fill_addr_n      = fill_addr + ADDR_WIDTH'(1);
                    fill_remaining_n = fill_remaining - CNT_WIDTH'(1);
                    if (fill_remaining == CNT_WIDTH'(1)) begin
                        state_n     = S_DONE;
                        fill_busy_n = 1'b0;
                        fill_done_n = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n     = S_IDLE;
                fill_busy_n = 1'b0;
            end
            default: begin
                state_n     = S_IDLE;
                fill_busy_n = 1'b0;
            end
        endcase

        if (cpu_issue) begin
            ram_addr   = cpu.cpu_addr;
            ram_wrdata = cpu.cpu_wrdata;
            ram_wren   = cpu.cpu_wr;
        end else begin
            ram_addr   = fill_addr;
            ram_wrdata = fill_word;
            ram_wren   = fill_wr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            fill_addr      <= '0;
            fill_remaining <= '0;
            fill_word      <= '0;
            fill_busy      <= 1'b0;
            fill_done      <= 1'b0;
            cpu_ack_q      <= 1'b0;
            rd_pend        <= 1'b0;
            rd_hold        <= '0;
        end else begin
            state          <= state_n;
            fill_addr      <= fill_addr_n;
            fill_remaining <= fill_remaining_n;
            fill_word      <= fill_word_n;
            fill_busy      <= fill_busy_n;
            fill_done      <= fill_done_n;
            cpu_ack_q      <= cpu_issue;
            rd_pend        <= cpu_issue && !cpu.cpu_wr;
            if (rd_pend) begin
                rd_hold <= ram_rddata;
            end
        end
    end

    // RAM read data lands in the ack cycle: forward it then, hold it afterwards.
    assign cpu.cpu_ack    = cpu_ack_q;
    assign cpu.cpu_rddata = rd_pend ? ram_rddata : rd_hold;

endmodule
